// File: rtl/core_control_pkg.sv
// core_control_pkg: shared state, opcode, instruction-class and control-field encodings
// for the multi-cycle control sequencer.
package core_control_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_FETCH     = 3'd1;
    localparam state_t S_DECODE    = 3'd2;
    localparam state_t S_EXECUTE   = 3'd3;
    localparam state_t S_MEMORY    = 3'd4;
    localparam state_t S_WRITEBACK = 3'd5;
    localparam state_t S_HALTED    = 3'd6;

    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_FENCE  = 7'h0F;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    // CLS_NONE doubles as the reset value and the "unknown opcode" marker.
    typedef enum logic [3:0] {
        CLS_NONE, CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BRANCH,
        CLS_LOAD, CLS_STORE, CLS_OPIMM, CLS_OP, CLS_FENCE, CLS_SYSTEM
    } class_t;

    localparam logic [1:0] RD_ALU  = 2'd0;
    localparam logic [1:0] RD_LOAD = 2'd1;
    localparam logic [1:0] RD_PC4  = 2'd2;
    localparam logic [1:0] RD_IMMU = 2'd3;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_RS1   = 2'd2;

    localparam logic [1:0] HALT_NONE    = 2'd0;
    localparam logic [1:0] HALT_SYSTEM  = 2'd1;
    localparam logic [1:0] HALT_ILLEGAL = 2'd2;
    localparam logic [1:0] HALT_TIMEOUT = 2'd3;

    function automatic class_t classify(input logic [6:0] opc);
        case (opc)
            OPC_LUI:    return CLS_LUI;
            OPC_AUIPC:  return CLS_AUIPC;
            OPC_JAL:    return CLS_JAL;
            OPC_JALR:   return CLS_JALR;
            OPC_BRANCH: return CLS_BRANCH;
            OPC_LOAD:   return CLS_LOAD;
            OPC_STORE:  return CLS_STORE;
            OPC_OPIMM:  return CLS_OPIMM;
            OPC_OP:     return CLS_OP;
            OPC_FENCE:  return CLS_FENCE;
            OPC_SYSTEM: return CLS_SYSTEM;
            default:    return CLS_NONE;
        endcase
    endfunction

    function automatic logic bad_funct3(input class_t c, input logic [2:0] f);
        return (c == CLS_LOAD && (f == 3'd3 || f >= 3'd6)) ||
               (c == CLS_STORE && f > 3'd2) ||
               (c == CLS_BRANCH && (f == 3'd2 || f == 3'd3));
    endfunction

endpackage

// File: rtl/access_timer.sv
// access_timer: saturating wait counter for the memory phase; expired_o rises once
// LIMIT cycles have elapsed since the last clear (LIMIT=0 never expires).
module access_timer #(
    parameter int LIMIT = 255
) (
    input  logic clock,
    input  logic nReset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

    logic [W-1:0] count_q, count_d;

    assign expired_o = (LIMIT != 0) && (count_q == W'(LIMIT));

    always_comb count_d = clear_i ? '0 : (enable_i && !expired_o) ? count_q + 1'b1 : count_q;

    always_ff @(posedge clock or negedge nReset)
        if (!nReset) count_q <= '0;
        else         count_q <= count_d;

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK controller with
// sticky halt on system, illegal or memory-timeout conditions and a retired counter.
module control_sequencer
    import core_control_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        nReset,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    output logic        instrReq,
    input  logic        instrAck,
    output logic        irLoad,
    output logic        dataReq,
    output logic        dataWrite,
    input  logic        dataAck,
    input  logic        branchTaken,
    output logic        rdWriteEnable,
    output logic [1:0]  rdSource,
    output logic [2:0]  immSelect,
    output logic        pcUpdate,
    output logic [1:0]  pcSelect,
    output logic        halted,
    output logic [1:0]  haltCause,
    output logic [31:0] retiredCount
);
    state_t      state_q, state_d;
    class_t      cls_q, cls_d, dec_cls;
    logic        taken_q, taken_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] retired_q, retired_d;
    logic        expired, active, is_jump;

    access_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
        .clock    (clock),
        .nReset   (nReset),
        .clear_i  (state_q != S_MEMORY),
        .enable_i (state_q == S_MEMORY),
        .expired_o(expired)
    );

    assign dec_cls = classify(opcode);

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        taken_d   = taken_q;
        cause_d   = cause_q;
        retired_d = retired_q;
        case (state_q)
            S_IDLE:      state_d = S_FETCH;
            S_FETCH:     state_d = instrAck ? S_DECODE : S_FETCH;
            S_DECODE: begin
                cls_d = dec_cls;
                if (dec_cls == CLS_SYSTEM) begin
                    state_d = S_HALTED;
                    cause_d = HALT_SYSTEM;
                end else if (dec_cls == CLS_NONE || bad_funct3(dec_cls, funct3)) begin
                    state_d = S_HALTED;
                    cause_d = HALT_ILLEGAL;
                end else
                    state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                taken_d = branchTaken;
                state_d = (cls_q == CLS_LOAD || cls_q == CLS_STORE) ? S_MEMORY : S_WRITEBACK;
            end
            // an acknowledge arriving on the expiry cycle still completes the access
            S_MEMORY: begin
                if (dataAck)
                    state_d = S_WRITEBACK;
                else if (expired) begin
                    state_d = S_HALTED;
                    cause_d = HALT_TIMEOUT;
                end
            end
            S_WRITEBACK: begin
                retired_d = retired_q + 32'd1;
                state_d   = S_FETCH;
            end
            default:     state_d = state_q;
        endcase
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q   <= S_IDLE;
            cls_q     <= CLS_NONE;
            taken_q   <= 1'b0;
            cause_q   <= HALT_NONE;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            taken_q   <= taken_d;
            cause_q   <= cause_d;
            retired_q <= retired_d;
        end
    end

    assign active        = state_q == S_EXECUTE || state_q == S_MEMORY || state_q == S_WRITEBACK;
    assign is_jump       = cls_q == CLS_JAL || cls_q == CLS_JALR;
    assign instrReq      = state_q == S_FETCH;
    assign irLoad        = instrReq && instrAck;
    assign dataReq       = state_q == S_MEMORY;
    assign dataWrite     = dataReq && cls_q == CLS_STORE;
    assign pcUpdate      = state_q == S_WRITEBACK;
    assign rdWriteEnable = pcUpdate && (is_jump || cls_q == CLS_LUI || cls_q == CLS_AUIPC ||
                           cls_q == CLS_LOAD || cls_q == CLS_OPIMM || cls_q == CLS_OP);
    assign rdSource      = !active ? RD_ALU : cls_q == CLS_LOAD ? RD_LOAD :
                           is_jump ? RD_PC4 : cls_q == CLS_LUI ? RD_IMMU : RD_ALU;
    assign immSelect     = !active ? IMM_I : cls_q == CLS_STORE ? IMM_S : cls_q == CLS_BRANCH ? IMM_B :
                           (cls_q == CLS_LUI || cls_q == CLS_AUIPC) ? IMM_U : cls_q == CLS_JAL ? IMM_J : IMM_I;
    assign pcSelect      = !pcUpdate ? PC_PLUS4 :
                           (cls_q == CLS_JAL || (cls_q == CLS_BRANCH && taken_q)) ? PC_IMM :
                           cls_q == CLS_JALR ? PC_RS1 : PC_PLUS4;
    assign halted        = state_q == S_HALTED;
    assign haltCause     = cause_q;
    assign retiredCount  = retired_q;

endmodule
